bkm_steps_ctrl: RTL and testbench

BKM_STEPS_CTRL -- requirements
Module: bkm_steps_ctrl

---
 rtl/bkm_steps_ctrl.sv | 159 +++++++++++++++
 tb/tb_bkm_steps_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_steps_ctrl.sv
// rtl/bkm_steps_ctrl.sv - BKM step sequencer: IDLE/LOAD/RUN/DONE control for the step datapath
//
// Purpose: sequences one BKM operation. It pulses load once, then asserts
// step_en for N_ITER enabled cycles with the step index n counting
// 0..N_ITER-1. It then holds out_valid until out_ready is seen.
// Optional feature macro: BKM_STEPS_CTRL_OPCNT_EN. When it is defined,
// op_count counts completed handshakes and saturates at 16'hFFFF. When it
// is undefined, op_count is tied to 0.
//
// Ports:
//   clk        - clock, all state on rising edge
//   arst       - asynchronous active-high reset
//   srst       - synchronous active-high reset, independent of enable
//   enable     - global clock-enable; 0 freezes all state
//   start      - request new operation (IDLE only)
//   abort      - cancel operation in LOAD/RUN
//   mode_in    - operation mode (E/L)
//   format_in  - number format
//   out_ready  - consumer accepts result
//   ready      - controller idle, start accepted
//   load       - step registers load initial X/Y/u/v
//   step_en    - step registers capture next iterate
//   n          - current step index
//   mode       - mode latched at start
//   format     - format latched at start
//   busy       - LOAD or RUN
//   out_valid  - result final and stable
//   op_count   - completed-operation counter
module bkm_steps_ctrl #(
  parameter int LOG2N  = 6,
  parameter int N_ITER = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_in,
  input  logic [1:0]       format_in,
  input  logic             out_ready,
  output logic             ready,
  output logic             load,
  output logic             step_en,
  output logic [LOG2N-1:0] n,
  output logic             mode,
  output logic [1:0]       format,
  output logic             busy,
  output logic             out_valid,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] N_LAST = LOG2N'(N_ITER - 1);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic             mode_q, mode_d;
  logic [1:0]       format_q, format_d;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      mode_q   <= 1'b0;
      format_q <= 2'b00;
    end else if (srst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      mode_q   <= 1'b0;
      format_q <= 2'b00;
    end else if (enable) begin
      state_q  <= state_d;
      n_q      <= n_d;
      mode_q   <= mode_d;
      format_q <= format_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    mode_d    = mode_q;
    format_d  = format_q;
    ready     = 1'b0;
    load      = 1'b0;
    step_en   = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          mode_d   = mode_in;
          format_d = format_in;
          n_d      = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        load    = enable;
        n_d     = '0;
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        step_en = enable;
        // Abort takes priority over the final step, so no DONE is produced.
        if (abort) begin
          n_d     = '0;
          state_d = S_IDLE;
        end else if (n_q == N_LAST) begin
          n_d     = '0;
          state_d = S_DONE;
        end else begin
          n_d = n_q + LOG2N'(1);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign n      = n_q;
  assign mode   = mode_q;
  assign format = format_q;

`ifdef BKM_STEPS_CTRL_OPCNT_EN
  logic [15:0] op_count_q;
  logic        done_ack;

  assign done_ack = (state_q == S_DONE) && out_ready && enable;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      op_count_q <= '0;
    end else if (srst) begin
      op_count_q <= '0;
    end else if (done_ack && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'd0;
`endif

endmodule

// File: tb/tb_bkm_steps_ctrl.sv
// tb/tb_bkm_steps_ctrl.sv - directed self-checking bench for bkm_steps_ctrl
module tb_bkm_steps_ctrl;

`ifdef BKM_STEPS_CTRL_OPCNT_EN
  localparam int OPC_EN = 1;
`else
  localparam int OPC_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        arst, srst, enable, start, abort, mode_in, out_ready;
  logic [1:0]  format_in;
  logic        ready, load, step_en, mode, busy, out_valid;
  logic [5:0]  n;
  logic [1:0]  format;
  logic [15:0] op_count;
  logic        u1_ready, u1_load, u1_step_en, u1_mode, u1_busy, u1_out_valid;
  logic [5:0]  u1_n;
  logic [1:0]  u1_format;
  logic [15:0] u1_op_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cnt;
  int guard;

  always #5 clk = ~clk;

  bkm_steps_ctrl #(.LOG2N(6), .N_ITER(4)) u0 (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
    .abort(abort), .mode_in(mode_in), .format_in(format_in), .out_ready(out_ready),
    .ready(ready), .load(load), .step_en(step_en), .n(n), .mode(mode),
    .format(format), .busy(busy), .out_valid(out_valid), .op_count(op_count)
  );

  bkm_steps_ctrl #(.LOG2N(6), .N_ITER(1)) u1 (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
    .abort(abort), .mode_in(mode_in), .format_in(format_in), .out_ready(out_ready),
    .ready(u1_ready), .load(u1_load), .step_en(u1_step_en), .n(u1_n), .mode(u1_mode),
    .format(u1_format), .busy(u1_busy), .out_valid(u1_out_valid), .op_count(u1_op_count)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    arst = 0; srst = 0; enable = 1; start = 0; abort = 0;
    mode_in = 0; format_in = 2'b00; out_ready = 1;
    #1 arst = 1;
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_n", 32'(n), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_format", 32'(format), 0);
    chk("rst_opcount", 32'(op_count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_step_en", 32'(step_en), 0);
    cyc;
    arst = 0;
    cyc;

    // basic op, N_ITER=4, with latched mode/format
    start = 1; mode_in = 1; format_in = 2'b10;
    chk("t1_ready", 32'(ready), 1);
    cyc;
    start = 0; mode_in = 0; format_in = 2'b01;
    chk("t1_load", 32'(load), 1);
    chk("t1_load_busy", 32'(busy), 1);
    chk("t1_load_n", 32'(n), 0);
    chk("t1_load_mode", 32'(mode), 1);
    chk("t1_load_format", 32'(format), 2);
    chk("t1_load_step_en", 32'(step_en), 0);
    cyc;
    chk("t1_u1_step_en", 32'(u1_step_en), 1);
    chk("t1_u1_n", 32'(u1_n), 0);
    for (int k = 0; k < 4; k++) begin
      mode_in = ~mode_in; format_in = format_in + 2'b01;
      chk("t1_step_en", 32'(step_en), 1);
      chk("t1_n", 32'(n), 32'(k));
      chk("t1_run_mode", 32'(mode), 1);
      chk("t1_run_format", 32'(format), 2);
      chk("t1_load_low", 32'(load), 0);
      if (k == 1) chk("t1_u1_out_valid", 32'(u1_out_valid), 1);
      cyc;
    end
    chk("t1_done_out_valid", 32'(out_valid), 1);
    chk("t1_done_step_en", 32'(step_en), 0);
    chk("t1_done_n", 32'(n), 0);
    chk("t1_done_mode", 32'(mode), 1);
    chk("t1_done_format", 32'(format), 2);
    chk("t1_done_ready", 32'(ready), 0);
    cyc;
    chk("t1_idle_ready", 32'(ready), 1);
    chk("t1_idle_out_valid", 32'(out_valid), 0);
    chk("t1_opcount", 32'(op_count), 32'(OPC_EN * 1));

    // abort at n=2
    start = 1;
    cyc;
    start = 0;
    cyc; cyc; cyc;
    chk("t2_n2", 32'(n), 2);
    abort = 1;
    cyc;
    abort = 0;
    chk("t2_ready", 32'(ready), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_n", 32'(n), 0);
    chk("t2_out_valid", 32'(out_valid), 0);
    chk("t2_opcount", 32'(op_count), 32'(OPC_EN * 1));
    cyc;
    chk("t2_out_valid_later", 32'(out_valid), 0);
    chk("t2_ready_later", 32'(ready), 1);

    // abort coinciding with the final step
    start = 1;
    cyc;
    start = 0;
    cyc; cyc; cyc; cyc;
    chk("t2b_n3", 32'(n), 3);
    abort = 1;
    cyc;
    abort = 0;
    chk("t2b_ready", 32'(ready), 1);
    chk("t2b_out_valid", 32'(out_valid), 0);

    // enable=0 for 3 cycles at n=1
    out_ready = 0; mode_in = 0; format_in = 2'b11; start = 1;
    cyc;
    start = 0;
    cyc;
    cnt = 0;
    cnt = cnt + 32'(step_en);
    cyc;
    chk("t3_n1", 32'(n), 1);
    enable = 0;
    #1;
    chk("t3_gate_step_en", 32'(step_en), 0);
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("t3_hold_n", 32'(n), 1);
      chk("t3_hold_step_en", 32'(step_en), 0);
      chk("t3_hold_busy", 32'(busy), 1);
    end
    enable = 1;
    #1;
    chk("t3_resume_n", 32'(n), 1);
    guard = 0;
    while (!out_valid && guard < 10) begin
      cnt = cnt + 32'(step_en);
      cyc;
      guard++;
    end
    chk("t3_step_pulses", 32'(cnt), 4);
    chk("t3_out_valid", 32'(out_valid), 1);

    // DONE held while out_ready=0; start ignored
    mode_in = 1; format_in = 2'b00; start = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_out_valid", 32'(out_valid), 1);
      chk("t4_hold_ready", 32'(ready), 0);
      cyc;
    end
    chk("t4_still_valid", 32'(out_valid), 1);
    chk("t4_mode", 32'(mode), 0);
    chk("t4_format", 32'(format), 3);
    start = 0; out_ready = 1;
    cyc;
    chk("t4_idle_ready", 32'(ready), 1);
    chk("t4_idle_out_valid", 32'(out_valid), 0);
    chk("t4_opcount", 32'(op_count), 32'(OPC_EN * 2));
    cyc;
    chk("t4_no_restart", 32'(ready), 1);
    chk("t4_no_restart_busy", 32'(busy), 0);

    // arst mid-RUN, then srst mid-LOAD with enable low
    mode_in = 1; format_in = 2'b10; start = 1;
    cyc;
    start = 0;
    cyc; cyc;
    chk("t5_n1", 32'(n), 1);
    chk("t5_mode_pre", 32'(mode), 1);
    arst = 1;
    #1;
    chk("t5_arst_ready", 32'(ready), 1);
    chk("t5_arst_busy", 32'(busy), 0);
    chk("t5_arst_n", 32'(n), 0);
    chk("t5_arst_mode", 32'(mode), 0);
    chk("t5_arst_format", 32'(format), 0);
    chk("t5_arst_opcount", 32'(op_count), 0);
    arst = 0;
    cyc;
    start = 1;
    cyc;
    start = 0;
    chk("t5_load", 32'(load), 1);
    chk("t5_load_format", 32'(format), 2);
    srst = 1; enable = 0;
    #1;
    chk("t5_load_gated", 32'(load), 0);
    cyc;
    srst = 0; enable = 1;
    #1;
    chk("t5_srst_ready", 32'(ready), 1);
    chk("t5_srst_busy", 32'(busy), 0);
    chk("t5_srst_n", 32'(n), 0);
    chk("t5_srst_mode", 32'(mode), 0);
    chk("t5_srst_format", 32'(format), 0);
    chk("t5_srst_out_valid", 32'(out_valid), 0);
    chk("t5_srst_load", 32'(load), 0);
    cyc;
    chk("t5_idle_ready", 32'(ready), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
